// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the seven-segment display blocks
// Purpose: blank-state output codes and the active-low hex-to-cathode table.
// Ports: none (package).
package seg7_pkg;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low cathodes {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low seven-segment decoder
// Purpose: maps a 4-bit hex digit to cathode drive levels.
// Ports:
//   nibble  in  4  hex digit
//   seg     out 7  cathodes {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed seven-segment scan driver
// Purpose: holds a 16-bit hex value, scans four digits with dead time between
// slots, and swaps in newly loaded data only at frame boundaries.
// Ports:
//   CLK_100MHZ  in  1   system clock, rising edge
//   RST         in  1   asynchronous active-high reset
//   VALUE       in  16  digit k = VALUE[4k+3:4k]
//   DP_IN       in  4   decimal point per digit, 1 = lit
//   BLANK       in  4   per-digit blank mask, 1 = dark
//   LOAD        in  1   strobe capturing VALUE/DP_IN/BLANK
//   AN          out 8   anodes, active-low, AN[7:4] held high
//   SEG         out 7   cathodes {g..a}, active-low
//   DP          out 1   decimal-point cathode, active-low
//   FRAME_DONE  out 1   one-cycle pulse after digit 3's slot ends
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int DEAD       = 2
) (
  input  logic        CLK_100MHZ,
  input  logic        RST,
  input  logic [15:0] VALUE,
  input  logic [3:0]  DP_IN,
  input  logic [3:0]  BLANK,
  input  logic        LOAD,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME_DONE
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_C  = CNT_W'(DEAD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [15:0]      pend_value_q, pend_value_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic [3:0]       pend_blank_q, pend_blank_d;
  logic [15:0]      shadow_value_q, shadow_value_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       shadow_blank_q, shadow_blank_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             boundary;
  logic             lit;
  logic [3:0]       cur_nibble;
  logic [6:0]       dec_seg;

  hex_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == 2'd3);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;

    pend_d         = pend_q;
    pend_value_d   = pend_value_q;
    pend_dp_d      = pend_dp_q;
    pend_blank_d   = pend_blank_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;

    if (LOAD) begin
      pend_d       = 1'b1;
      pend_value_d = VALUE;
      pend_dp_d    = DP_IN;
      pend_blank_d = BLANK;
    end

    // A LOAD coinciding with the boundary bypasses pending so it is shown
    // in the very next slot; either way nothing stays pending afterwards.
    if (boundary) begin
      pend_d = 1'b0;
      if (LOAD) begin
        shadow_value_d = VALUE;
        shadow_dp_d    = DP_IN;
        shadow_blank_d = BLANK;
      end else if (pend_q) begin
        shadow_value_d = pend_value_q;
        shadow_dp_d    = pend_dp_q;
        shadow_blank_d = pend_blank_q;
      end
    end

    cur_nibble = shadow_value_q[{idx_q, 2'b00} +: 4];
    lit        = (cnt_q >= DEAD_C) && !shadow_blank_q[idx_q];

    an_d         = lit ? (AN_OFF & ~(8'b1 << idx_q)) : AN_OFF;
    seg_d        = lit ? dec_seg : SEG_OFF;
    dp_d         = lit ? ~shadow_dp_q[idx_q] : 1'b1;
    frame_done_d = boundary;
  end

  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      pend_q         <= 1'b0;
      pend_value_q   <= '0;
      pend_dp_q      <= '0;
      pend_blank_q   <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_q           <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pend_q         <= pend_d;
      pend_value_q   <= pend_value_d;
      pend_dp_q      <= pend_dp_d;
      pend_blank_q   <= pend_blank_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [6:0] exp_seg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_driver #(
    .CLK_HZ     (40),
    .REFRESH_HZ (4),
    .DEAD       (2)
  ) dut (
    .CLK_100MHZ (clk),
    .RST        (rst),
    .VALUE      (value),
    .DP_IN      (dp_in),
    .BLANK      (blank),
    .LOAD       (load),
    .AN         (an),
    .SEG        (seg),
    .DP         (dp),
    .FRAME_DONE (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing on the following falling edge.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic goto_cyc(input int k);
    adv(k - cyc);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg);
    chk({tag, "_an"}, 32'(an), 32'(e_an));
    chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
  endtask

  initial begin
    rst   = 1'b1;
    value = '0;
    dp_in = '0;
    blank = '0;
    load  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'h0FF);
    chk("rst_seg", 32'(seg), 32'h07F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    cyc = 0;

    // Load 1234 at cycle 5; old shadow (zero) keeps showing "0" until cycle 40.
    goto_cyc(4);
    value = 16'h1234;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
    goto_cyc(25);
    chk_out("pre_frame_d2", 8'hFB, 7'b1000000);
    goto_cyc(39);
    chk("fd_before", 32'(frame_done), 32'h0);
    goto_cyc(40);
    chk("fd_pulse1", 32'(frame_done), 32'h1);
    goto_cyc(41);
    chk("fd_after", 32'(frame_done), 32'h0);
    chk_out("dead_c1", 8'hFF, 7'h7F);
    goto_cyc(42);
    chk_out("dead_c2", 8'hFF, 7'h7F);
    goto_cyc(43);
    chk_out("d0_first_lit", 8'hFE, 7'b0011001);
    chk("d0_dp", 32'(dp), 32'h1);
    goto_cyc(50);
    chk_out("d0_last_lit", 8'hFE, 7'b0011001);
    goto_cyc(51);
    chk_out("d1_dead", 8'hFF, 7'h7F);
    goto_cyc(53);
    chk_out("d1_lit", 8'hFD, 7'b0110000);
    goto_cyc(63);
    chk_out("d2_lit", 8'hFB, 7'b0100100);
    goto_cyc(73);
    chk_out("d3_lit", 8'hF7, 7'b1111001);

    // Two loads before the boundary: the second one wins.
    value = 16'hAAAA;
    load  = 1'b1;
    adv(1);
    value = 16'h0F0F;
    adv(1);
    load  = 1'b0;
    goto_cyc(83);
    chk_out("lw_d0", 8'hFE, 7'b0001110);
    goto_cyc(93);
    chk_out("lw_d1", 8'hFD, 7'b1000000);
    goto_cyc(103);
    chk_out("lw_d2", 8'hFB, 7'b0001110);
    goto_cyc(113);
    chk_out("lw_d3", 8'hF7, 7'b1000000);
    goto_cyc(119);
    chk("fd_before2", 32'(frame_done), 32'h0);
    goto_cyc(120);
    chk("fd_pulse2", 32'(frame_done), 32'h1);

    // Pending 9999, then LOAD 5678 on the boundary tick: 5678 wins, pend clears.
    goto_cyc(129);
    value = 16'h9999;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
    goto_cyc(159);
    value = 16'h5678;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
    chk("bnd_pend", 32'(dut.pend_q), 32'h0);
    goto_cyc(163);
    chk_out("bnd_d0", 8'hFE, 7'b0000000);
    goto_cyc(173);
    chk_out("bnd_d1", 8'hFD, 7'b1111000);
    goto_cyc(203);
    chk_out("bnd_next_frame", 8'hFE, 7'b0000000);

    // Blank digits 0 and 2, decimal point on digit 3.
    goto_cyc(204);
    value = 16'h1234;
    blank = 4'b0101;
    dp_in = 4'b1000;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
    goto_cyc(243);
    chk_out("blk_d0", 8'hFF, 7'h7F);
    chk("blk_d0_dp", 32'(dp), 32'h1);
    goto_cyc(253);
    chk_out("blk_d1", 8'hFD, 7'b0110000);
    chk("blk_d1_dp", 32'(dp), 32'h1);
    goto_cyc(263);
    chk_out("blk_d2", 8'hFF, 7'h7F);
    goto_cyc(272);
    chk("dp_dead", 32'(dp), 32'h1);
    chk("an_dead", 32'(an), 32'h0FF);
    goto_cyc(273);
    chk_out("dp_d3", 8'hF7, 7'b1111001);
    chk("dp_d3_lit", 32'(dp), 32'h0);

    // Unblank, then reset in the middle of digit 2's lit window.
    value = 16'h1234;
    blank = 4'b0000;
    dp_in = 4'b0000;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
    goto_cyc(305);
    chk_out("pre_rst_d2", 8'hFB, 7'b0100100);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 8'hFF, 7'h7F);
    chk("async_rst_dp", 32'(dp), 32'h1);
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    goto_cyc(2);
    chk_out("post_rst_dead", 8'hFF, 7'h7F);
    goto_cyc(3);
    chk_out("post_rst_zero", 8'hFE, 7'b1000000);

    // Sweep every nibble on digit 0.
    for (int n = 0; n < 16; n++) begin
      value = 16'(n);
      load  = 1'b1;
      adv(1);
      load  = 1'b0;
      while (cyc % 40 != 3) adv(1);
      chk_out($sformatf("sweep_%0h", n), 8'hFE, exp_seg[n]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
